pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register replacing the hand-written fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field from one stage to the next and adds what the fixed registers lack:
- valid/ready back-pressure;
- an optional two-entry skid buffer, so upstream `in_ready` is registered;
- synchronous flush that inserts a bubble;
- an occupancy count.

Instantiated once per stage boundary in the MIPS pipeline.

## Interface
Parameters:
- `CTRL_W`, 16: control-field width (RegWrite, memWrite, ALU control, …); zeroed whenever the stage holds a bubble.
- `DATA_W`, 128: payload width (read data 1/2, instruction, PC); never zeroed except at reset.
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous bubble/flush request (branch mispredict, jump).
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_ctrl`  in  CTRL_W  upstream control bits.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream copy is valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_ctrl`  out  CTRL_W  registered control; 0 whenever `out_valid`=0.
- `out_data`  out  DATA_W  registered payload.
- `count`  out  2  entries held (0..2; max 1 when SKID=0).

## Operation
- Transfer definitions:
  - `in_fire` = `in_valid & in_ready`.
  - `out_fire` = `out_valid & out_ready`.
- Storage:
  - Main entry drives `out_*`.
  - Skid entry exists only if SKID=1.
- State machine, SKID=1, with states EMPTY, ONE, TWO; `count` = 0/1/2 respectively.
  - EMPTY: `in_fire` → ONE, main ← in.
  - ONE:
    - `in_fire` & `out_fire` → ONE, main ← in.
    - `in_fire` & !`out_fire` → TWO, skid ← in.
    - !`in_fire` & `out_fire` → EMPTY.
    - Otherwise hold.
  - TWO: `out_fire` → ONE, main ← skid. `in_ready`=0, so no input is taken.
  - `in_ready` is a register: 1 in EMPTY/ONE, 0 in TWO.
- SKID=0:
  - States are EMPTY/ONE only.
  - `in_ready` = !`out_valid` | `out_ready` (combinational).
  - Simultaneous in/out fire reloads main.
- Flush has the highest priority, over any fire:
  - Next state is EMPTY; `out_valid` ← 0; `out_ctrl` ← 0; `in_ready` ← 1.
  - Data accepted in the flush cycle is discarded.
  - An `out_fire` in the flush cycle still counts as delivered downstream.
- Bubble guarantee:
  - Every transition to EMPTY clears `out_ctrl` to 0.
  - `out_data` retains its last value and is don't-care.
- No arithmetic; `count` never exceeds 2 and never wraps.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `count`=0.
  - `in_ready`=1; skid entry = 0; state EMPTY.
- Release of `rst_n` is sampled at the next rising edge. Reset asserted mid-operation discards all held entries immediately.
- Latency is 1 cycle: an `in_fire` at edge N gives `out_valid`=1 with that data after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- When `out_ready` drops:
  - SKID=1: one more input is absorbed; `in_ready` falls after that edge.
  - SKID=0: `in_ready` falls in the same cycle.
- Ordering is strictly FIFO; the skid entry is never bypassed.

## Structure
- Shared package `pipe_pkg` holds:
  - enum `pipe_state_t` {ST_EMPTY, ST_ONE, ST_TWO};
  - localparam `PIPE_CNT_W` = 2.
- No sub-module. SKID=0/1 are generate branches in one module.
- Per-boundary wrappers pack their named fields into `in_ctrl`/`in_data`.

## Test plan
- Reset: with `rst_n`=0 mid-stream holding 2 entries, all outputs go to reset values asynchronously; `in_ready`=1; `count`=0.
- Streaming, SKID=1, `out_ready`=1: feed ctrl 0x0001..0x0005 on consecutive cycles → each appears 1 cycle later, no gaps, `count` stays 1.
- Back-pressure: `out_ready`=0 while feeding ctrl 0x00A1, 0x00A2 → `count`=2 and `in_ready`=0. Then `out_ready`=1 → outputs 0x00A1, then 0x00A2, in order; none lost or duplicated.
- Flush: with `count`=2, assert `flush` together with `in_valid` ctrl 0x00FF → next cycle `out_valid`=0, `out_ctrl`=0, `count`=0, `in_ready`=1; 0x00FF never appears.
- SKID=0: `out_ready`=0 with one entry held → `in_ready`=0 in the same cycle. Toggling `out_ready` high with `in_valid` high in the same cycle → main is reloaded, `count` stays 1.
- Random valid/ready, about 10k cycles, both SKID values: a scoreboard checks order and data integrity, that `out_ctrl`=0 whenever `out_valid`=0, and that `count` ≤ 2.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and widths for pipe_stage_reg
package pipe_pkg;

    localparam int PIPE_CNT_W = 2;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} pipe_state_t;

    function automatic logic [PIPE_CNT_W-1:0] state_count(input pipe_state_t s);
        return (s == ST_TWO) ? 2'd2 : (s == ST_ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry, flush and occupancy
//   clk, rst_n (async, active-low), flush (sync bubble insert)
//   in_valid/in_ready/in_ctrl/in_data   : upstream handshake and fields
//   out_valid/out_ready/out_ctrl/out_data: downstream handshake and fields
//   count                                 : entries held (0..2)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_t       r_state;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;
    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign out_ctrl    = r_main_ctrl;
    assign out_data    = r_main_data;
    assign count       = state_count(r_state);

    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            logic              r_in_ready;
            assign w_in_ready = r_in_ready;
            // in_ready is registered: it is low exactly while both entries are full
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state     <= ST_EMPTY;
                    r_main_ctrl <= '0;
                    r_main_data <= '0;
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                    r_in_ready  <= 1'b1;
                end else if (flush) begin
                    r_state     <= ST_EMPTY;
                    r_main_ctrl <= '0;
                    r_in_ready  <= 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                r_state     <= ST_ONE;
                                r_main_ctrl <= in_ctrl;
                                r_main_data <= in_data;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                r_main_ctrl <= in_ctrl;
                                r_main_data <= in_data;
                            end else if (w_in_fire) begin
                                r_state     <= ST_TWO;
                                r_skid_ctrl <= in_ctrl;
                                r_skid_data <= in_data;
                                r_in_ready  <= 1'b0;
                            end else if (w_out_fire) begin
                                r_state     <= ST_EMPTY;
                                r_main_ctrl <= '0;
                            end
                        end
                        ST_TWO: begin
                            if (w_out_fire) begin
                                r_state     <= ST_ONE;
                                r_main_ctrl <= r_skid_ctrl;
                                r_main_data <= r_skid_data;
                                r_in_ready  <= 1'b1;
                            end
                        end
                        default: begin
                            r_state     <= ST_EMPTY;
                            r_main_ctrl <= '0;
                            r_in_ready  <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_noskid
            assign w_in_ready = !w_out_valid | out_ready;
            // an in_fire while full implies out_fire, so it simply reloads main
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state     <= ST_EMPTY;
                    r_main_ctrl <= '0;
                    r_main_data <= '0;
                end else if (flush) begin
                    r_state     <= ST_EMPTY;
                    r_main_ctrl <= '0;
                end else if (w_in_fire) begin
                    r_state     <= ST_ONE;
                    r_main_ctrl <= in_ctrl;
                    r_main_data <= in_data;
                end else if (w_out_fire) begin
                    r_state     <= ST_EMPTY;
                    r_main_ctrl <= '0;
                end
            end
        end
    endgenerate

endmodule
